i2s_sample_scheduler: RTL



---
 rtl/audio_pkg.sv | 12 +
 rtl/sample_fifo.sv | 64 ++++++
 rtl/i2s_sample_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types and default constants for the sample scheduler and I2S transmitter.
package audio_pkg;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } sched_state_t;

  localparam int unsigned DEF_I2S_DATA_BITS      = 24;
  localparam int unsigned DEF_MCLK_FRAME_DIVIDER = 512;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample-pair FIFO with wrap-bit pointers, registered level and registered read data.
module sample_fifo #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  input  logic                       rd_clr,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot the push lands in, so a full FIFO still accepts a same-cycle write.
  assign push_ok = push && (!full_c || pop);
  assign pop_ok  = pop && !empty_c;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end else if (rd_clr) begin
        rd_data <= '0;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_sample_scheduler.sv
// Paces jittery decoder sample pairs into the I2S transmitter at one pair per frame, priming and muting on underrun.
module i2s_sample_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned I2S_DATA_BITS      = DEF_I2S_DATA_BITS,
  parameter int unsigned MCLK_FRAME_DIVIDER = DEF_MCLK_FRAME_DIVIDER,
  parameter int unsigned FIFO_DEPTH         = 8,
  parameter int unsigned PRIME_LEVEL        = 4
) (
  input  logic                             AMCLK_i,
  input  logic                             reset_n,
  input  logic [I2S_DATA_BITS-1:0]         IN_LEFT_i,
  input  logic [I2S_DATA_BITS-1:0]         IN_RIGHT_i,
  input  logic                             IN_VALID_i,
  input  logic                             STATUS_CLR_i,
  output logic [I2S_DATA_BITS-1:0]         APSDATA_LEFT_o,
  output logic [I2S_DATA_BITS-1:0]         APSDATA_RIGHT_o,
  output logic                             APDATA_VALID_o,
  output logic [$clog2(FIFO_DEPTH):0]      FILL_o,
  output logic                             RUNNING_o,
  output logic                             UNDERRUN_o,
  output logic                             OVERRUN_o
);

  localparam int unsigned DIV_W  = $clog2(MCLK_FRAME_DIVIDER);
  localparam int unsigned FILL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PAIR_W = 2 * I2S_DATA_BITS;

  logic [DIV_W-1:0]  frame_cnt;
  logic              tick_c;
  sched_state_t      state_q;
  sched_state_t      state_d;
  logic              pop_c;
  logic              mute_c;
  logic              push_c;
  logic              underrun_set_c;
  logic              overrun_set_c;
  logic              full_c;
  logic              empty_c;
  logic [FILL_W-1:0] level;
  logic [PAIR_W-1:0] rd_data;
  logic              valid_q;
  logic              running_q;
  logic              underrun_q;
  logic              overrun_q;

  // Free-running frame counter; wraps naturally because the divider is a power of two.
  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + DIV_W'(1);
    end
  end

  assign tick_c = (frame_cnt == DIV_W'(MCLK_FRAME_DIVIDER - 1));

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pop_c          = 1'b0;
    mute_c         = 1'b0;
    underrun_set_c = 1'b0;
    if (tick_c) begin
      case (state_q)
        PRIME: begin
          if (level >= FILL_W'(PRIME_LEVEL)) begin
            pop_c   = 1'b1;
            state_d = RUN;
          end else begin
            mute_c = 1'b1;
          end
        end
        RUN: begin
          if (!empty_c) begin
            pop_c = 1'b1;
          end else begin
            mute_c         = 1'b1;
            underrun_set_c = 1'b1;
            state_d        = PRIME;
          end
        end
        default: begin
          mute_c  = 1'b1;
          state_d = PRIME;
        end
      endcase
    end
  end

  assign push_c        = IN_VALID_i && (!full_c || pop_c);
  assign overrun_set_c = IN_VALID_i && full_c && !pop_c;

  sample_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (AMCLK_i),
    .rst_n   (reset_n),
    .push    (push_c),
    .wr_data ({IN_LEFT_i, IN_RIGHT_i}),
    .pop     (pop_c),
    .rd_clr  (mute_c),
    .rd_data (rd_data),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level   (level)
  );

  // Frame strobe, run indicator and sticky flags; a set event outranks a same-cycle clear.
  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      running_q  <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      valid_q   <= tick_c;
      running_q <= (state_d == RUN);
      if (underrun_set_c) begin
        underrun_q <= 1'b1;
      end else if (STATUS_CLR_i) begin
        underrun_q <= 1'b0;
      end
      if (overrun_set_c) begin
        overrun_q <= 1'b1;
      end else if (STATUS_CLR_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign APSDATA_LEFT_o  = rd_data[PAIR_W-1:I2S_DATA_BITS];
  assign APSDATA_RIGHT_o = rd_data[I2S_DATA_BITS-1:0];
  assign APDATA_VALID_o  = valid_q;
  assign FILL_o          = level;
  assign RUNNING_o       = running_q;
  assign UNDERRUN_o      = underrun_q;
  assign OVERRUN_o       = overrun_q;

endmodule
